// File: rtl/display_pkg.sv
// Shared constants, glyph table and FSM state type for the score display.
// Pure declarations: no timing of its own.
// No flow control; consumers evaluate the helpers combinationally.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Active-low gfedcba glyph for one decimal digit; non-decimal codes go dark.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic logic [63:0] max_display(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// Segment selector for one digit: off-phase, dash, blank or decimal glyph.
// Combinational, zero latency.
// No flow control.
module seg7_digit
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  input  logic       off,
  output logic [6:0] seg
);

  // Priority: blink off-phase, then overflow dash, then leading-zero blank.
  always_comb begin
    seg = glyph(bcd);
    if (off)        seg = SEG_BLANK;
    else if (dash)  seg = SEG_DASH;
    else if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/score_display.sv
// Binary score -> serial double-dabble BCD -> registered active-low 7-seg digits.
// Load at edge t: busy t+1..t+WIDTH+1, new hex and busy low at t+WIDTH+2.
// Loads while the converter is busy are dropped; no queueing.
module score_display
  import display_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int DIGITS     = 2,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int BW  = 4 * DIGITS;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [63:0] MAXV = max_display(DIGITS);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     bin;
  logic [BW-1:0]        scratch;
  logic [BW-1:0]        adj;
  logic [BW+WIDTH-1:0]  shifted;
  logic [CW-1:0]        iter;
  logic                 ovf_next;
  logic [BW-1:0]        disp_bcd;
  logic                 overflow_q;
  logic                 busy_q;
  logic [BCW-1:0]       blink_cnt;
  logic                 phase_on;
  logic                 off;
  logic [DIGITS-1:0]    blank_vec;
  logic [7*DIGITS-1:0]  seg_nxt;
  logic [7*DIGITS-1:0]  hex_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: capture on load, WIDTH shift steps, one commit cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (iter == CW'(WIDTH - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5, then shift {scratch, bin} left.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin} << 1;
  end

  // Conversion datapath, displayed BCD and overflow flag (updated together at commit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin        <= '0;
      scratch    <= '0;
      iter       <= '0;
      ovf_next   <= 1'b0;
      disp_bcd   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin      <= value;
          scratch  <= '0;
          iter     <= '0;
          ovf_next <= (64'(value) > MAXV);
        end
        CONVERT: begin
          {scratch, bin} <= shifted;
          iter           <= iter + CW'(1);
        end
        COMMIT: begin
          disp_bcd   <= scratch;
          overflow_q <= ovf_next;
        end
        default: ;
      endcase
    end
  end

  // busy is delayed one cycle so it drops in the same cycle the new digits appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= (state != IDLE);
  end

  // Blink half-period counter; held at zero with phase ON while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BCW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + BCW'(1);
    end
  end

  assign off = blink_en & ~phase_on;

  // Leading-zero blank: digit i>0 goes dark when it and every digit above are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp_bcd[4*i +: 4] == 4'd0);
      if (i > 0) blank_vec[i] = blank_lz & upper_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_digit u_digit (
      .bcd   (disp_bcd[4*g +: 4]),
      .blank (blank_vec[g]),
      .dash  (overflow_q),
      .off   (off),
      .seg   (seg_nxt[7*g +: 7])
    );
  end

  // Output register; reset shows "0" on every digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex_q <= {DIGITS{7'b1000000}};
    else        hex_q <= seg_nxt;
  end

  assign hex      = hex_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int W  = 7;
  localparam int D  = 2;
  localparam int BH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load = 1'b0;
  logic [W-1:0]   value = '0;
  logic           blank_lz = 1'b0;
  logic           blink_en = 1'b0;
  logic           busy;
  logic           overflow;
  logic [7*D-1:0] hex;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display #(.WIDTH(W), .DIGITS(D), .BLINK_HALF(BH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .busy     (busy),
    .overflow (overflow),
    .hex      (hex)
  );

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected steady display for integer v, computed digit by digit in decimal.
  function automatic logic [7*D-1:0] exp_hex(input int v, input bit blz);
    logic [7*D-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      if (v > 10**D - 1)            r[7*i +: 7] = 7'b0111111;
      else if (blz && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
      else                          r[7*i +: 7] = ref_glyph((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count remaining busy cycles until busy drops, then check the committed display.
  task automatic wait_done(input int v, input int pre, input string tag);
    int cnt;
    cnt = pre;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    check({tag, "_busy_len"}, 32'(cnt), 32'(W + 1));
    check({tag, "_hex"}, 32'(hex), 32'(exp_hex(v, blank_lz)));
    check({tag, "_ovf"}, 32'(overflow), 32'(v > 10**D - 1));
  endtask

  // Called at a falling edge: present load for one rising edge, then wait.
  task automatic do_load(input int v, input string tag);
    value = W'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check({tag, "_busy_t0"}, 32'(busy), 32'd0);
    wait_done(v, 0, tag);
  endtask

  initial begin
    int pre;
    int cnt;
    int v;

    #12;
    check("rst_hex",  32'(hex),      32'(exp_hex(0, 1'b0)));
    check("rst_busy", 32'(busy),     32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_hex", 32'(hex), 32'(exp_hex(0, 1'b0)));

    do_load(19, "v19");
    blank_lz = 1'b1;
    do_load(5, "v5_blz");
    do_load(0, "v0_blz");
    blank_lz = 1'b0;
    do_load(100, "v100_ovf");
    do_load(42, "v42");

    // Second load on the third busy cycle must be dropped.
    value = W'(12);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    pre  = 0;
    repeat (2) begin
      @(negedge clk);
      if (busy) pre++;
    end
    value = W'(34);
    load  = 1'b1;
    @(negedge clk);
    if (busy) pre++;
    load = 1'b0;
    wait_done(12, pre, "ign12");
    do_load(34, "v34");

    // Load presented in the last busy cycle is accepted as busy falls.
    value = W'(77);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt  = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (cnt == W + 1) break;
    end
    check("b2b_first_len", 32'(cnt), 32'(W + 1));
    value = W'(88);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("b2b_hex77",  32'(hex),  32'(exp_hex(77, 1'b0)));
    check("b2b_busy0",  32'(busy), 32'd0);
    wait_done(88, 0, "b2b88");

    // Randomized loads against the decimal model.
    repeat (12) begin
      v        = $urandom_range(0, 127);
      blank_lz = 1'($urandom_range(0, 1));
      do_load(v, "rand");
    end

    // blank_lz change shows one cycle later.
    blank_lz = 1'b0;
    do_load(7, "v07");
    blank_lz = 1'b1;
    @(negedge clk);
    check("blz_on",  32'(hex), 32'(exp_hex(7, 1'b1)));
    blank_lz = 1'b0;
    @(negedge clk);
    check("blz_off", 32'(hex), 32'(exp_hex(7, 1'b0)));

    // Blink: ON for BH cycles, then OFF for BH, starting from the enabling edge.
    blink_en = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      check("blink", 32'(hex), ((j / BH) % 2 == 1) ? 32'h3fff : 32'(exp_hex(7, 1'b0)));
    end
    blink_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("blink_stop", 32'(hex), 32'(exp_hex(7, 1'b0)));
    end
    blink_en = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      check("blink_again", 32'(hex), ((j / BH) % 2 == 1) ? 32'h3fff : 32'(exp_hex(7, 1'b0)));
    end
    blink_en = 1'b0;
    @(negedge clk);

    // Reset mid-conversion with overflow currently shown.
    do_load(100, "pre_rst_ovf");
    value = W'(55);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hex",  32'(hex),      32'(exp_hex(0, 1'b0)));
    check("mid_rst_busy", 32'(busy),     32'd0);
    check("mid_rst_ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_hex", 32'(hex), 32'(exp_hex(0, 1'b0)));
    do_load(55, "v55");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
